// File: rtl/segre_pkg.sv
// Shared core types and constants: word/address sizes, the NOP encoding and fetch-stage types.
package segre_pkg;

  localparam int unsigned WORD_SIZE     = 32;
  localparam int unsigned ADDR_SIZE     = 32;
  localparam int unsigned IF_FIFO_DEPTH = 2;

  // addi x0, x0, 0
  localparam logic [WORD_SIZE-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IF_IDLE,
    IF_REQ,
    IF_WAIT
  } if_state_e;

  typedef struct packed {
    logic [WORD_SIZE-1:0] instr;
    logic [ADDR_SIZE-1:0] pc;
  } fetch_entry_t;

  function automatic logic [ADDR_SIZE-1:0] word_align(input logic [ADDR_SIZE-1:0] addr);
    return addr & ~ADDR_SIZE'(3);
  endfunction

endpackage

// File: rtl/segre_fetch_fifo.sv
// Small synchronous FIFO of fetched {instr, pc} pairs with flush; circular pointers wrap at FIFO_DEPTH.
module segre_fetch_fifo
  import segre_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = IF_FIFO_DEPTH,
  localparam int unsigned PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rsn_i,
  input  logic             push_i,
  input  fetch_entry_t     push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output fetch_entry_t     head_o,
  output logic [CNT_W-1:0] count_o
);

  fetch_entry_t     mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  // Pointer and occupancy update; flush wins over push/pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read once it has been written.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/segre_if_stage.sv
// Instruction fetch stage: owns the fetch PC, issues one-outstanding word reads and buffers
// returned instructions for ID; redirects flush the buffer and squash an in-flight response.
module segre_if_stage
  import segre_pkg::*;
#(
  parameter logic [ADDR_SIZE-1:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int unsigned          FIFO_DEPTH = IF_FIFO_DEPTH
) (
  input  logic                 clk_i,
  input  logic                 rsn_i,
  input  logic                 fetch_en_i,
  output logic                 mem_req_o,
  output logic [ADDR_SIZE-1:0] mem_addr_o,
  input  logic                 mem_gnt_i,
  input  logic                 mem_rvalid_i,
  input  logic [WORD_SIZE-1:0] mem_rdata_i,
  input  logic                 block_if_i,
  input  logic                 redirect_i,
  input  logic [ADDR_SIZE-1:0] redirect_pc_i,
  output logic [WORD_SIZE-1:0] instr_o,
  output logic [ADDR_SIZE-1:0] pc_o,
  output logic                 valid_if_o
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  if_state_e            state_q, state_d;
  logic [ADDR_SIZE-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_SIZE-1:0] req_pc_q, req_pc_d;
  logic                 discard_q, discard_d;

  logic                 fifo_valid;
  logic                 fill;
  logic                 pop;
  logic                 issue_ok;
  logic [CNT_W-1:0]     count;
  logic [CNT_W:0]       count_next;
  fetch_entry_t         push_entry;
  fetch_entry_t         head;

  assign fifo_valid = (count != '0);
  assign fill       = mem_rvalid_i & (state_q == IF_WAIT) & ~discard_q & ~redirect_i;
  assign pop        = fifo_valid & ~block_if_i & ~redirect_i;
  assign count_next = (CNT_W+1)'(count) + (CNT_W+1)'(fill) - (CNT_W+1)'(pop);
  // A new request must find a slot free after this cycle's fill/pop: that slot is its reservation.
  assign issue_ok   = fetch_en_i & ~redirect_i & ~discard_q
                    & (count_next < (CNT_W+1)'(FIFO_DEPTH));
  assign push_entry = '{instr: mem_rdata_i, pc: req_pc_q};

  segre_fetch_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fetch_fifo (
    .clk_i       (clk_i),
    .rsn_i       (rsn_i),
    .push_i      (fill),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (redirect_i),
    .head_o      (head),
    .count_o     (count)
  );

  assign valid_if_o = fifo_valid;
  assign instr_o    = fifo_valid ? head.instr : NOP_INSTR;
  assign pc_o       = fifo_valid ? head.pc    : '0;

  // Request FSM: next state, fetch PC bookkeeping and memory request outputs.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    discard_d  = discard_q;
    mem_req_o  = 1'b0;
    mem_addr_o = fetch_pc_q;

    if (discard_q && mem_rvalid_i) discard_d = 1'b0;

    if (redirect_i) begin
      state_d    = IF_IDLE;
      fetch_pc_d = word_align(redirect_pc_i);
      if ((state_q == IF_WAIT) && !mem_rvalid_i) discard_d = 1'b1;
    end else begin
      case (state_q)
        IF_IDLE: begin
          if (issue_ok) state_d = IF_REQ;
        end
        IF_REQ: begin
          mem_req_o = 1'b1;
          if (mem_gnt_i) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + ADDR_SIZE'(4);
            state_d    = IF_WAIT;
          end
        end
        IF_WAIT: begin
          if (mem_rvalid_i) begin
            mem_req_o = issue_ok;
            if (!issue_ok) begin
              state_d = IF_IDLE;
            end else if (mem_gnt_i) begin
              req_pc_d   = fetch_pc_q;
              fetch_pc_d = fetch_pc_q + ADDR_SIZE'(4);
              state_d    = IF_WAIT;
            end else begin
              state_d = IF_REQ;
            end
          end
        end
        default: state_d = IF_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q    <= IF_IDLE;
      fetch_pc_q <= BOOT_ADDR;
      req_pc_q   <= '0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      discard_q  <= discard_d;
    end
  end

  a_no_fill_when_full: assert property (@(posedge clk_i) disable iff (!rsn_i)
    !(fill && (count == CNT_W'(FIFO_DEPTH))));

  a_no_orphan_rvalid: assert property (@(posedge clk_i) disable iff (!rsn_i)
    !(mem_rvalid_i && (state_q != IF_WAIT) && !discard_q));

  a_req_held_until_gnt: assert property (@(posedge clk_i) disable iff (!rsn_i)
    (mem_req_o && !mem_gnt_i) |=> (redirect_i || (mem_req_o && $stable(mem_addr_o))));

endmodule

// File: tb/tb_segre_if_stage.sv
// Directed bench for segre_if_stage: a queue-based reference of the fetch stage checked every cycle,
// plus hand-computed expectations for reset, streaming, blocking, redirects, grant stalls and wrap.
module tb_segre_if_stage;
  import segre_pkg::*;

  localparam int unsigned DEPTH = IF_FIFO_DEPTH;
  localparam logic [31:0] BOOT  = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rsn_i = 1'b0;
  logic        fetch_en_i = 1'b0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        block_if_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        valid_if_o;

  segre_if_stage #(.BOOT_ADDR(BOOT), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i         (clk_i),
    .rsn_i         (rsn_i),
    .fetch_en_i    (fetch_en_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i),
    .block_if_i    (block_if_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .valid_if_o    (valid_if_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory: grants while gnt_en, answers lat cycles after the grant.
  int          lat       = 1;
  bit          gnt_en    = 1'b1;
  int          pend_cnt  = 0;
  logic [31:0] pend_addr = '0;

  // Reference model: fetch pointer, request/outstanding flags, discard flag and a queue of entries.
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;
  typedef struct packed {
    logic fill;
    logic pop;
    logic issue;
    logic req;
  } pred_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  logic [31:0] m_req_pc;
  bit          m_reqp;
  bit          m_out;
  bit          m_disc;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc     = BOOT;
    m_req_pc = '0;
    m_reqp   = 1'b0;
    m_out    = 1'b0;
    m_disc   = 1'b0;
  endtask

  function automatic pred_t predict();
    pred_t p;
    int    n;
    n       = mq.size();
    p.fill  = mem_rvalid_i && m_out && !m_disc && !redirect_i;
    p.pop   = (n != 0) && !block_if_i && !redirect_i;
    p.issue = fetch_en_i && !redirect_i && !m_disc && ((n + int'(p.fill) - int'(p.pop)) < int'(DEPTH));
    p.req   = !redirect_i && (m_reqp || (m_out && mem_rvalid_i && p.issue));
    return p;
  endfunction

  task automatic model_step(input pred_t p);
    bit idle;
    if (!rsn_i) begin
      model_reset();
      return;
    end
    if (redirect_i) begin
      mq.delete();
      if (m_disc) begin
        if (mem_rvalid_i) m_disc = 1'b0;
      end else if (m_out && !mem_rvalid_i) begin
        m_disc = 1'b1;
      end
      m_out  = 1'b0;
      m_reqp = 1'b0;
      m_pc   = redirect_pc_i & ~32'd3;
      return;
    end
    if (p.pop)  void'(mq.pop_front());
    if (p.fill) mq.push_back('{instr: mem_rdata_i, pc: m_req_pc});
    if (m_disc && mem_rvalid_i) m_disc = 1'b0;
    idle = !m_reqp && !m_out;
    if (p.req && mem_gnt_i) begin
      m_req_pc = m_pc;
      m_pc     = m_pc + 32'd4;
      m_out    = 1'b1;
      m_reqp   = 1'b0;
    end else if (p.req) begin
      m_reqp = 1'b1;
      m_out  = 1'b0;
    end else begin
      if (m_out && mem_rvalid_i) m_out = 1'b0;
      if (idle && p.issue) m_reqp = 1'b1;
    end
  endtask

  // One clock: drive inputs after the falling edge, compare against the model, then advance
  // model and memory to the state they hold after the next rising edge.
  task automatic drive(input bit rsn, input bit fe, input bit blk, input bit rd, input logic [31:0] rpc);
    pred_t p;
    @(negedge clk_i);
    rsn_i         = rsn;
    fetch_en_i    = fe;
    block_if_i    = blk;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    mem_gnt_i     = gnt_en;
    mem_rvalid_i  = (pend_cnt == 1);
    mem_rdata_i   = (pend_cnt == 1) ? instr_of(pend_addr) : 32'hDEAD_BEEF;
    #2;
    p = predict();
    chk("valid_if_o", 32'(valid_if_o), 32'(mq.size() != 0));
    chk("instr_o", instr_o, (mq.size() != 0) ? mq[0].instr : NOP_INSTR);
    chk("pc_o", pc_o, (mq.size() != 0) ? mq[0].pc : 32'h0);
    chk("mem_req_o", 32'(mem_req_o), 32'(p.req));
    if (p.req) chk("mem_addr_o", mem_addr_o, m_pc);
    model_step(p);
    if (pend_cnt > 0) pend_cnt--;
    if (mem_req_o && mem_gnt_i) begin
      pend_cnt  = lat;
      pend_addr = mem_addr_o;
    end
  endtask

  task automatic wait_req(input string name, input logic [31:0] exp_addr);
    bit found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      drive(1, 1, 0, 0, 0);
      if (mem_req_o) begin
        found = 1'b1;
        chk(name, mem_addr_o, exp_addr);
      end
    end
    chk({name, "_seen"}, 32'(found), 32'd1);
  endtask

  task automatic wait_valid(input string name, input logic [31:0] exp_pc);
    bit found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      drive(1, 1, 0, 0, 0);
      if (valid_if_o) begin
        found = 1'b1;
        chk(name, pc_o, exp_pc);
        chk({name, "_instr"}, instr_o, instr_of(exp_pc));
      end
    end
    chk({name, "_seen"}, 32'(found), 32'd1);
  endtask

  initial begin
    logic [31:0] head_pc;
    logic [31:0] last_pc;
    bit          synced;

    model_reset();
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    chk("rst_valid", 32'(valid_if_o), 32'd0);
    chk("rst_instr", instr_o, 32'h0000_0013);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_req", 32'(mem_req_o), 32'd0);

    // Streaming from reset with single-cycle memory.
    for (int k = 0; k <= 5; k++) begin
      drive(1, 1, 0, 0, 0);
      if (k == 0) chk("t1_no_req_at_release", 32'(mem_req_o), 32'd0);
      if (k >= 1 && k <= 3) begin
        chk("t1_req", 32'(mem_req_o), 32'd1);
        chk("t1_addr", mem_addr_o, 32'(4 * (k - 1)));
      end
      if (k >= 3) begin
        chk("t1_valid", 32'(valid_if_o), 32'd1);
        chk("t1_pc", pc_o, 32'(4 * (k - 3)));
        chk("t1_instr", instr_o, instr_of(32'(4 * (k - 3))));
      end
    end

    // ID blocked for 5 cycles: buffer fills to depth, requests stop, head holds.
    head_pc = '0;
    for (int b = 0; b < 5; b++) begin
      drive(1, 1, 1, 0, 0);
      if (b == 0) begin
        head_pc = pc_o;
        chk("t2_head", pc_o, 32'h0000_000C);
      end else begin
        chk("t2_head_stable", pc_o, head_pc);
      end
      chk("t2_valid", 32'(valid_if_o), 32'd1);
      chk("t2_no_req", 32'(mem_req_o), 32'd0);
    end
    last_pc = 32'h8;
    for (int r = 0; r < 7; r++) begin
      drive(1, 1, 0, 0, 0);
      if (valid_if_o) begin
        chk("t2_order", pc_o, last_pc + 32'd4);
        last_pc = pc_o;
      end
    end

    // Redirect while a granted request waits on a two-cycle memory.
    lat    = 2;
    synced = 1'b0;
    for (int i = 0; i < 20 && !synced; i++) begin
      drive(1, 1, 0, 0, 0);
      if (pend_cnt == 2) synced = 1'b1;
    end
    chk("t3_sync", 32'(synced), 32'd1);
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 1, 32'h0000_0103);
    drive(1, 1, 0, 0, 0);
    chk("t3_flushed", 32'(valid_if_o), 32'd0);
    wait_req("t3_addr", 32'h0000_0100);
    wait_valid("t3_pc", 32'h0000_0100);

    // Redirect coinciding with rvalid while one entry is buffered.
    lat    = 1;
    synced = 1'b0;
    for (int i = 0; i < 20 && !synced; i++) begin
      drive(1, 1, 0, 0, 0);
      if (pend_cnt == 1 && mq.size() == 1) synced = 1'b1;
    end
    chk("t4_sync", 32'(synced), 32'd1);
    drive(1, 1, 0, 1, 32'h0000_0200);
    chk("t4_one_entry", 32'(valid_if_o), 32'd1);
    drive(1, 1, 0, 0, 0);
    chk("t4_empty", 32'(valid_if_o), 32'd0);
    chk("t4_idle", 32'(mem_req_o), 32'd0);

    // Grant withheld for 4 cycles; fetch_en dropping does not withdraw the request.
    gnt_en = 1'b0;
    for (int g = 0; g < 4; g++) begin
      drive(1, (g < 2), 0, 0, 0);
      chk("t5_req_held", 32'(mem_req_o), 32'd1);
      chk("t5_addr_held", mem_addr_o, 32'h0000_0200);
    end
    gnt_en = 1'b1;
    drive(1, 1, 0, 0, 0);
    chk("t5_granted_addr", mem_addr_o, 32'h0000_0200);
    drive(1, 1, 0, 0, 0);
    chk("t5_next_addr", mem_addr_o, 32'h0000_0204);
    drive(1, 1, 0, 0, 0);
    chk("t5_pc", pc_o, 32'h0000_0200);

    // Reset mid-IF_WAIT; the response to the squashed request returns while reset is held.
    synced = 1'b0;
    for (int i = 0; i < 20 && !synced; i++) begin
      drive(1, 1, 0, 0, 0);
      if (pend_cnt == 1 && mem_req_o) synced = 1'b1;
    end
    chk("t6_sync", 32'(synced), 32'd1);
    @(posedge clk_i);
    #1;
    rsn_i = 1'b0;
    model_reset();
    #1;
    chk("t6_rst_req", 32'(mem_req_o), 32'd0);
    chk("t6_rst_valid", 32'(valid_if_o), 32'd0);
    chk("t6_rst_instr", instr_o, 32'h0000_0013);
    chk("t6_rst_pc", pc_o, 32'h0);
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    wait_req("t6_boot_addr", BOOT);
    wait_valid("t6_boot_pc", BOOT);

    // Fetch PC wraps past the top of the address space.
    drive(1, 1, 0, 1, 32'hFFFF_FFFC);
    wait_req("t6_wrap_hi", 32'hFFFF_FFFC);
    drive(1, 1, 0, 0, 0);
    chk("t6_wrap_lo_req", 32'(mem_req_o), 32'd1);
    chk("t6_wrap_lo", mem_addr_o, 32'h0000_0000);
    wait_valid("t6_wrap_pc", 32'hFFFF_FFFC);
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
